if_fetch_seg: RTL and testbench

//  Fetch stage plus IF/ID segment register, directly upstream of the ID/EX segment.

---
 rtl/if_fetch_seg_pkg.sv | 35 +++
 rtl/if_fetch_seg_if.sv | 10 +
 rtl/if_fetch_seg_fetch_fifo.sv | 52 +++++
 rtl/if_fetch_seg.sv | 129 ++++++++++++
 tb/tb_if_fetch_seg.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_seg_pkg.sv
// rtl/if_fetch_seg_pkg.sv - Shared fetch-stage types, field positions and reset PC
package if_fetch_seg_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Instruction field bit positions, shared with the control decoder
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int SHF_HI  = 10;
  localparam int SHF_LO  = 6;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int TGT_HI  = 25;
  localparam int TGT_LO  = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_seg_if.sv
// rtl/if_fetch_seg_if.sv - Instruction-memory request/response bus
interface if_fetch_seg_if;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] rdata;

  modport master (output req, output addr, input valid, input rdata);
  modport slave  (input req, input addr, output valid, output rdata);
endinterface

// File: rtl/if_fetch_seg_fetch_fifo.sv
// rtl/if_fetch_seg_fetch_fifo.sv - Fetch buffer with read-through head and synchronous clear
module fetch_fifo
  import if_fetch_seg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign do_pop    = pop && !empty && !clr;
  // A full buffer still accepts a push when the head leaves on the same edge
  assign do_push   = push && !clr && ((count != CW'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_seg.sv
// rtl/if_fetch_seg.sv - Fetch stage: PC, imem request FSM, IF/ID buffer and field split
module if_fetch_seg
  import if_fetch_seg_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  if_fetch_seg_if.master imem,
  input  logic           Load_Use,
  input  logic           Branch_fc,
  input  logic           Jump_fc,
  input  logic [31:0]    redirect_pc,
  output logic           inst_valid,
  output logic [31:0]    pc_out,
  output logic [5:0]     op_out,
  output logic [5:0]     func_out,
  output logic [4:0]     rs_out,
  output logic [4:0]     rt_out,
  output logic [4:0]     rd_out,
  output logic [4:0]     shf_out,
  output logic [15:0]    imm16_out,
  output logic [25:0]    target_out
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   drop_addr, drop_addr_next;
  logic          flush;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after_pop;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [31:0]   head_instr;

  assign flush           = Branch_fc | Jump_fc;
  assign pop             = !fifo_empty && !Load_Use;
  assign count_after_pop = fifo_count - CW'(pop);
  assign push_entry      = {pc, imem.rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      drop_addr <= drop_addr_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    drop_addr_next = drop_addr;
    issue          = 1'b0;
    push           = 1'b0;
    case (state)
      ST_RUN: begin
        issue = (count_after_pop < CW'(FIFO_DEPTH));
        if (issue) begin
          if (imem.valid) begin
            if (!flush) begin
              push    = 1'b1;
              pc_next = pc + 32'd4;
            end
          end else begin
            // A request already on the bus must run to completion even if redirected
            state_next = flush ? ST_DROP : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        issue = 1'b1;
        if (imem.valid) begin
          state_next = ST_RUN;
          if (!flush) begin
            push    = 1'b1;
            pc_next = pc + 32'd4;
          end
        end else if (flush) begin
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        issue = 1'b1;
        if (imem.valid) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    if (flush) pc_next = redirect_pc;
    if (state != ST_DROP && state_next == ST_DROP) drop_addr_next = pc;
  end

  assign imem.req  = issue & rst_n;
  assign imem.addr = (state == ST_DROP) ? drop_addr : pc;

  assign inst_valid = !fifo_empty;
  assign head_instr = fifo_empty ? '0 : head.instr;
  assign pc_out     = fifo_empty ? '0 : head.pc + 32'd4;
  assign op_out     = head_instr[OP_HI:OP_LO];
  assign rs_out     = head_instr[RS_HI:RS_LO];
  assign rt_out     = head_instr[RT_HI:RT_LO];
  assign rd_out     = head_instr[RD_HI:RD_LO];
  assign shf_out    = head_instr[SHF_HI:SHF_LO];
  assign func_out   = head_instr[FUNC_HI:FUNC_LO];
  assign imm16_out  = head_instr[IMM_HI:IMM_LO];
  assign target_out = head_instr[TGT_HI:TGT_LO];

endmodule

// File: tb/tb_if_fetch_seg.sv
// tb/tb_if_fetch_seg.sv - Self-checking bench for if_fetch_seg
module tb_if_fetch_seg;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b1;
  logic        rst_n;
  logic        Load_Use, Branch_fc, Jump_fc;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] pc_out;
  logic [5:0]  op_out, func_out;
  logic [4:0]  rs_out, rt_out, rd_out, shf_out;
  logic [15:0] imm16_out;
  logic [25:0] target_out;
  logic [106:0] dut_id;

  if_fetch_seg_if bus ();

  if_fetch_seg #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .Load_Use(Load_Use), .Branch_fc(Branch_fc), .Jump_fc(Jump_fc), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .pc_out(pc_out), .op_out(op_out), .func_out(func_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .shf_out(shf_out),
    .imm16_out(imm16_out), .target_out(target_out)
  );

  assign dut_id = {inst_valid, pc_out, op_out, rs_out, rt_out, rd_out, shf_out, func_out, imm16_out, target_out};

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    int          lu;
    int          vld;
    int          e_req;
    logic [31:0] e_addr;
    int          e_iv;
    logic [31:0] e_pcout;
  } vec_t;

  // Reference: in-order queue of fetched words, the next fetch PC and at most one outstanding request
  ent_t        mq[$];
  logic [31:0] m_pc, m_paddr;
  bit          m_pend, m_disc;
  int          n_checks, n_pass, cyc;
  string       phase;
  vec_t        tbl[9];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [106:0] id_of(input ent_t e);
    return {1'b1, e.pc + 32'd4, e.instr[31:26], e.instr[25:21], e.instr[20:16], e.instr[15:11],
            e.instr[10:6], e.instr[5:0], e.instr[15:0], e.instr[25:0]};
  endfunction

  function automatic vec_t mk(input int lu, input int vld, input int e_req, input logic [31:0] e_addr,
                              input int e_iv, input logic [31:0] e_pcout);
    vec_t v;
    v.lu = lu; v.vld = vld; v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pcout = e_pcout;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s cycle %0d: got %0h expected %0h", phase, name, cyc, act, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.valid = 1'b0;
    Load_Use = 1'b0; Branch_fc = 1'b0; Jump_fc = 1'b0;
    #1;
    check("rst_req", bus.req, 1'b0);
    check("rst_id", dut_id, '0);
    mq.delete();
    m_pc = RST_PC; m_pend = 0; m_disc = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input int lu, input int br, input int jp, input logic [31:0] rpc, input int vld,
                      input int chk, input int e_req, input logic [31:0] e_addr, input int e_iv,
                      input logic [31:0] e_pcout);
    bit pop, req, done, push, fl;
    logic [31:0]  addr;
    logic [106:0] e_id;
    @(posedge clk); #1;
    Load_Use = (lu != 0); Branch_fc = (br != 0); Jump_fc = (jp != 0); redirect_pc = rpc;
    fl   = (br != 0) || (jp != 0);
    pop  = (mq.size() != 0) && (lu == 0);
    req  = m_pend || ((mq.size() - int'(pop)) < DEPTH);
    addr = m_pend ? m_paddr : m_pc;
    e_id = (mq.size() != 0) ? id_of(mq[0]) : '0;
    #1;
    bus.valid = (vld != 0) && req;
    bus.rdata = mem_word(bus.addr);
    #1;
    check("imem_req", bus.req, req);
    check("imem_addr", bus.addr, addr);
    check("id_outputs", dut_id, e_id);
    if (chk != 0) begin
      check("vec_req", bus.req, e_req);
      check("vec_addr", bus.addr, e_addr);
      check("vec_inst_valid", inst_valid, e_iv);
      check("vec_pc_out", pc_out, e_pcout);
    end
    cyc++;
    done = req && (vld != 0);
    push = done && !fl && !m_disc;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{pc: addr, instr: mem_word(addr)});
    end
    if (done) begin
      m_pend = 0; m_disc = 0;
      if (push) m_pc = addr + 32'd4;
    end else if (req) begin
      m_pend = 1; m_paddr = addr;
      if (fl) m_disc = 1;
    end
    if (fl) m_pc = rpc;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    rst_n = 1'b0; Load_Use = 1'b0; Branch_fc = 1'b0; Jump_fc = 1'b0; redirect_pc = '0;
    bus.valid = 1'b0; bus.rdata = '0;

    tbl[0] = mk(0, 1, 1, 32'h3000, 0, 32'h0);
    tbl[1] = mk(0, 1, 1, 32'h3004, 1, 32'h3004);
    tbl[2] = mk(0, 1, 1, 32'h3008, 1, 32'h3008);
    tbl[3] = mk(1, 1, 1, 32'h300C, 1, 32'h300C);
    tbl[4] = mk(1, 1, 0, 32'h3010, 1, 32'h300C);
    tbl[5] = mk(1, 1, 0, 32'h3010, 1, 32'h300C);
    tbl[6] = mk(0, 1, 1, 32'h3010, 1, 32'h300C);
    tbl[7] = mk(0, 1, 1, 32'h3014, 1, 32'h3010);
    tbl[8] = mk(0, 1, 1, 32'h3018, 1, 32'h3014);

    phase = "zero_wait_and_load_use";
    do_reset();
    for (int i = 0; i < 9; i++)
      step(tbl[i].lu, 0, 0, 32'h0, tbl[i].vld, 1, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_iv, tbl[i].e_pcout);

    phase = "jump_in_wait";
    do_reset();
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3000, 0, 32'h0);
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3004, 1, 32'h3004);
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3008, 1, 32'h3008);
    step(0, 0, 0, 32'h0,    0, 1, 1, 32'h300C, 1, 32'h300C);
    step(0, 0, 1, 32'h3400, 0, 1, 1, 32'h300C, 0, 32'h0);
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h300C, 0, 32'h0);
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3400, 0, 32'h0);
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3404, 1, 32'h3404);

    phase = "branch_with_valid";
    do_reset();
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3000, 0, 32'h0);
    step(0, 1, 0, 32'h3800, 1, 1, 1, 32'h3004, 1, 32'h3004);
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3800, 0, 32'h0);
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3804, 1, 32'h3804);

    phase = "branch_load_use_full";
    do_reset();
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3000, 0, 32'h0);
    step(1, 0, 0, 32'h0,    1, 1, 1, 32'h3004, 1, 32'h3004);
    step(1, 0, 0, 32'h0,    1, 1, 0, 32'h3008, 1, 32'h3004);
    step(1, 1, 0, 32'h3C00, 1, 1, 0, 32'h3008, 1, 32'h3004);
    step(1, 0, 0, 32'h0,    1, 1, 1, 32'h3C00, 0, 32'h0);
    step(0, 0, 0, 32'h0,    1, 1, 1, 32'h3C04, 1, 32'h3C04);

    phase = "reset_mid_wait";
    do_reset();
    step(0, 0, 0, 32'h0, 1, 1, 1, 32'h3000, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 1, 1, 32'h3004, 1, 32'h3004);
    step(0, 0, 0, 32'h0, 1, 1, 1, 32'h3008, 1, 32'h3008);
    step(0, 0, 0, 32'h0, 1, 1, 1, 32'h300C, 1, 32'h300C);
    step(1, 0, 0, 32'h0, 0, 1, 1, 32'h3010, 1, 32'h3010);
    step(1, 0, 0, 32'h0, 0, 1, 1, 32'h3010, 1, 32'h3010);
    do_reset();
    step(0, 0, 0, 32'h0, 1, 1, 1, 32'h3000, 0, 32'h0);

    phase = "random";
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int          lu, br, jp, vld;
      logic [31:0] rpc;
      lu  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      br  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      jp  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      vld = int'($urandom_range(0, 1));
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'h0000_4000 + ($urandom_range(0, 255) << 2));
      step(lu, br, jp, rpc, vld, 0, 0, 32'h0, 0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
